// File: rtl/rtc_set_controller_if.sv
// rtc_set_controller_if: button inputs and time-setting outputs between debouncers, clock core and display
interface rtc_set_controller_if;
    logic       mode_i;
    logic       up_i;
    logic       set_hour_o;
    logic       set_min_o;
    logic       clock_run_o;
    logic       sec_clr_o;
    logic [3:0] blank_o;
    logic [1:0] mode_o;

    modport master (
        output mode_i, up_i,
        input  set_hour_o, set_min_o, clock_run_o, sec_clr_o, blank_o, mode_o
    );

    modport slave (
        input  mode_i, up_i,
        output set_hour_o, set_min_o, clock_run_o, sec_clr_o, blank_o, mode_o
    );
endinterface

// File: rtl/rtc_set_controller.sv
// rtc_set_controller: mode FSM, increment pulses with auto-repeat, blink mask and inactivity timeout
module rtc_set_controller #(
    parameter int BLINK_CYCLES   = 50000000,
    parameter int REPEAT_DELAY   = 50000000,
    parameter int REPEAT_RATE    = 10000000,
    parameter int TIMEOUT_CYCLES = 1000000000
) (
    input logic                clk_i,
    input logic                rst_i,
    rtc_set_controller_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10, UNUSED = 2'b11} state_t;

    localparam int HW = $clog2(REPEAT_DELAY + REPEAT_RATE) + 1;
    localparam int BW = $clog2(BLINK_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [HW-1:0] HOLD_FIRST  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY + REPEAT_RATE);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY + 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYCLES - 1);
    localparam logic [TW-1:0] IDLE_LAST   = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        state_next;
    logic          mode_q;
    logic          up_q;
    logic          mode_rise;
    logic          up_rise;
    logic          in_set;
    logic          next_in_set;
    logic          inc_event;
    logic          timeout;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_next;
    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic [TW-1:0] idle;
    logic          set_hour;
    logic          set_min;
    logic          sec_clr;

    // Edge detection, repeat scheduling and timeout decode; a hold count of 0 while up is held
    // means repeat is disarmed until a fresh press (after reset or a mode press that won the cycle).
    always_comb begin
        mode_rise   = bus.mode_i & ~mode_q;
        up_rise     = bus.up_i & ~up_q;
        in_set      = (state == SET_HR) || (state == SET_MIN);
        next_in_set = (state_next == SET_HR) || (state_next == SET_MIN);
        inc_event   = in_set & ~mode_rise
                    & (up_rise | (bus.up_i & ((hold == HOLD_FIRST) || (hold == HOLD_LAST))));
        timeout     = in_set & ~mode_rise & ~inc_event & (idle == IDLE_LAST);
        hold_next   = (!in_set || mode_rise || !bus.up_i) ? '0 :
                      up_rise                             ? HW'(1) :
                      (hold == '0)                        ? '0 :
                      (hold == HOLD_LAST)                 ? HOLD_RELOAD :
                                                            hold + HW'(1);
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= RUN;
        else        state <= state_next;
    end

    // Next state: mode press advances the cycle, inactivity falls back to RUN; code 11 behaves as RUN
    always_comb begin
        state_next = state;
        case (state)
            SET_HR:  state_next = mode_rise ? SET_MIN : timeout ? RUN : SET_HR;
            SET_MIN: state_next = (mode_rise || timeout) ? RUN : SET_MIN;
            default: state_next = mode_rise ? SET_HR : RUN;
        endcase
    end

    // Outputs decoded from the registered state, blink phase and pulse registers
    always_comb begin
        bus.mode_o      = in_set ? state : RUN;
        bus.clock_run_o = ~in_set;
        bus.blank_o     = (state == SET_HR)  ? {phase, phase, 2'b00} :
                          (state == SET_MIN) ? {2'b00, phase, phase} : 4'b0000;
        bus.set_hour_o  = set_hour;
        bus.set_min_o   = set_min;
        bus.sec_clr_o   = sec_clr;
    end

    // Button history, hold counter and inactivity counter; history resets high to mask held buttons
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mode_q <= 1'b1;
            up_q   <= 1'b1;
            hold   <= '0;
            idle   <= '0;
        end else begin
            mode_q <= bus.mode_i;
            up_q   <= bus.up_i;
            hold   <= hold_next;
            idle   <= (!in_set || mode_rise || inc_event) ? '0 : idle + TW'(1);
        end
    end

    // Blink phase: restarts visible on SET entry and on every increment, then toggles each half-period
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!next_in_set || (state_next != state) || inc_event) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Registered single-cycle pulses; seconds clear follows any SET_MIN to RUN transition
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            set_hour <= 1'b0;
            set_min  <= 1'b0;
            sec_clr  <= 1'b0;
        end else begin
            set_hour <= inc_event & (state == SET_HR);
            set_min  <= inc_event & (state == SET_MIN);
            sec_clr  <= (state == SET_MIN) & (state_next == RUN);
        end
    end
endmodule
